uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter. Converts a parallel word into an asynchronous
//  frame: start bit, DBIT data bits LSB first, optional parity, stop bit(s).
//  Bit timing comes from an external oversampling tick (s_tick). At system
//  level, s_tick is the max_tick of a mod_m_counter with M = f_clk/(baud*OVS).
//  Sits beside the UART receiver, between the bus-side FIFO/register and the pad.
// PARAMETERS
//  DBIT       8   data bits per frame (5..9)
//  OVS        16  s_ticks per data/start/parity bit
//  SB_TICK    16  s_ticks for the stop period (16/24/32 = 1/1.5/2 stop bits at OVS=16)
//  PARITY_EN  0   1 = insert a parity bit after the data bits
//  PARITY_ODD 0   parity sense when PARITY_EN=1: 0 = even, 1 = odd
// PORTS
//  clk           in   1     system clock
//  reset         in   1     synchronous, active-high reset
//  tx_start      in   1     request to send din; level-sensitive, sampled in IDLE only
//  s_tick        in   1     oversampling enable; single-clk pulse
//  din           in   DBIT  word to transmit; captured in the accept cycle
//  tx_busy       out  1     1 whenever the state is not IDLE
//  tx_done_tick  out  1     one-clk pulse when the stop period completes
//  tx            out  1     serial line; idle high; driven from a register (glitch-free)
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high.
//  - Reset values: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, tick/bit counters=0.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx=1. If tx_start=1, latch din into the shift register, compute parity,
//    clear the tick counter and go to START. A 0 appears on tx one clk after accept.
//  - START: tx=0. Count s_ticks. On the s_tick where the count is OVS-1, clear the
//    count and the bit index, then go to DATA.
//  - DATA: tx = shift_reg[0]. On each OVS-th s_tick, shift right and increment the
//    bit index. After bit DBIT-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
//  - PARITY: tx = ^latched_data ^ PARITY_ODD. Lasts OVS s_ticks, then go to STOP.
//  - STOP: tx=1. On the s_tick where the count is SB_TICK-1, pulse tx_done_tick for
//    exactly one clk and go to IDLE in that same cycle.
//  - Ticks: the tick counter advances only on clks with s_tick=1. Clks without
//    s_tick hold all state. Tick counter width is $clog2(max(OVS,SB_TICK)).
//    Bit index width is $clog2(DBIT).
//  - tx_start outside IDLE is ignored; no queuing. din changes after the accept
//    cycle have no effect on the frame in flight.
//  - tx_start=1 in the tx_done_tick cycle is ignored, because the state is still STOP.
//    If tx_start is still high on the next clk, it is accepted; minimum idle gap = 1 clk.
//  - Back-to-back: if tx_start is held high, a new frame starts every frame_len+1 clks.
//  - Reset mid-frame: tx=1 and state=IDLE on the next clk; no tx_done_tick is issued.
//  - An s_tick in the accept clk is not counted toward the START bit.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    tx_state_t enum {IDLE, START, DATA, PARITY, STOP}, default OVS/SB_TICK constants,
//    and a function baud_div(f_clk, baud, ovs) giving M for mod_m_counter.
//  - No sub-module. Single FSM with registered outputs (tx_reg, done_reg).
//  - The tick source (mod_m_counter) is instantiated at the UART top, not inside this block.
// TESTING
//  1. DBIT=8, OVS=16, SB_TICK=16, s_tick tied to 1, din=8'hA5, one-clk tx_start
//     -> tx bits (16 clks each) = 0,1,0,1,0,0,1,0,1,1;
//     tx_done_tick exactly 160 clks after tx falls; tx_busy high throughout.
//  2. Same setup, PARITY_EN=1, PARITY_ODD=0, din=8'h07 -> parity bit = 1;
//     frame = 176 clks. Repeat with PARITY_ODD=1 -> parity bit = 0.
//  3. s_tick every 4th clk, din=8'h3C -> each bit lasts 64 clks;
//     line holds its value between ticks; frame = 640 clks.
//  4. Pulse tx_start and change din at clks 5, 50 and 150 of a frame
//     -> no effect on the frame in flight; exactly one tx_done_tick.
//  5. tx_start held high, din=8'h55 -> consecutive frames separated by 1 idle clk;
//     tx_start in the done cycle is not double-accepted.
//  6. Assert reset at clk 70 of a frame -> tx=1, tx_busy=0 on the next clk,
//     no tx_done_tick; a new frame starts cleanly afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks.
//   tx_state_t  : transmitter FSM states
//   DEF_OVS     : default s_ticks per start/data/parity bit
//   DEF_SB_TICK : default s_ticks for the stop period (one stop bit at OVS=16)
//   baud_div()  : modulus M for the mod_m_counter that generates s_tick,
//                 M = f_clk / (baud * ovs), rounded to nearest
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DEF_OVS     = 16;
    localparam int DEF_SB_TICK = 16;

    function automatic int baud_div(input longint f_clk, input longint baud, input int ovs);
        longint den;
        den = baud * longint'(ovs);
        if (den <= 0) begin
            return 0;
        end
        return int'((f_clk + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter: start bit, DBIT data bits LSB first, optional
// parity bit, then the stop period. Bit timing is taken from an external
// oversampling enable (s_tick); state only advances on clocks with s_tick=1.
//
// Ports
//   clk           in   1     system clock
//   reset         in   1     synchronous, active-high reset
//   tx_start      in   1     send request, level-sensitive, only looked at in IDLE
//   s_tick        in   1     oversampling enable, single-clk pulse
//   din           in   DBIT  word to send, captured in the accept cycle
//   tx_busy       out  1     high whenever the FSM is not in IDLE
//   tx_done_tick  out  1     one-clk pulse in the cycle the stop period ends
//   tx            out  1     serial line, idle high, driven from a register
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | line low for OVS s_ticks
// DATA   | line = shift_reg[0], one bit per OVS s_ticks, DBIT bits
// PARITY | line = parity of the latched word (only when PARITY_EN=1)
// STOP   | line high for SB_TICK s_ticks, then done pulse and IDLE
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVS        = DEF_OVS,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] OVS_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
    localparam logic          ODD_SENSE = (PARITY_ODD != 0);

    tx_state_t       state_reg, state_next;
    logic [TW-1:0]   tick_reg,  tick_next;
    logic [BW-1:0]   bit_reg,   bit_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            par_reg,   par_next;
    logic            tx_reg,    tx_next;
    logic            done_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        done_tick  = 1'b0;

        case (state_reg)
            IDLE: begin
                // An s_tick coinciding with the accept cycle is deliberately
                // not counted: the START count begins from zero next clk.
                if (tx_start) begin
                    shift_next = din;
                    par_next   = (^din) ^ ODD_SENSE;
                    tick_next  = '0;
                    state_next = START;
                end
            end

            START: begin
                if (s_tick) begin
                    if (tick_reg == OVS_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = DATA;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (tick_reg == OVS_LAST) begin
                        tick_next  = '0;
                        shift_next = shift_reg >> 1;
                        if (bit_reg == BIT_LAST) begin
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (s_tick) begin
                    if (tick_reg == OVS_LAST) begin
                        tick_next  = '0;
                        state_next = STOP;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (tick_reg == SB_LAST) begin
                        tick_next  = '0;
                        done_tick  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The line level is decoded from the *next* state and registered, so tx
    // changes exactly on the clock that enters each bit and never glitches.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

    // The done pulse marks the last clock of the stop period while the state
    // is still STOP, so a tx_start in that same clock is not accepted. It is
    // masked during reset so an aborted frame never reports completion.
    assign tx_done_tick = done_tick & ~reset;
    assign tx_busy      = (state_reg != IDLE);
    assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic       s_tick;
    logic [7:0] din;

    logic tx0, busy0, done0;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
        .tx_busy(busy0), .tx_done_tick(done0), .tx(tx0));

    uart_tx #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
        .tx_busy(busy1), .tx_done_tick(done1), .tx(tx1));

    uart_tx #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
        .tx_busy(busy2), .tx_done_tick(done2), .tx(tx2));

    // sel: 0 = no parity, 1 = even parity, 2 = odd parity instance
    int   sel = 0;
    logic tx_m, busy_m, done_m;

    always_comb begin
        tx_m   = tx0;
        busy_m = busy0;
        done_m = done0;
        case (sel)
            1: begin tx_m = tx1; busy_m = busy1; done_m = done1; end
            2: begin tx_m = tx2; busy_m = busy2; done_m = done2; end
            default: ;
        endcase
    end

    typedef struct {
        logic val;
        int   clks;
        bit   last;
    } exp_bit_t;

    exp_bit_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int div   = 1;
    int ph    = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, update the tick enable for the coming
    // rising edge, then settle before any sampling or driving.
    task automatic step();
        @(negedge clk);
        ph     = (ph + 1 >= div) ? 0 : ph + 1;
        s_tick = (ph == 0);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input int par_mode);
        exp_bit_t e;
        int ones;
        e.clks = 16 * div;
        e.last = 1'b0;
        e.val  = 1'b0;
        exp_q.push_back(e);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            e.val = d[i];
            exp_q.push_back(e);
            if (d[i]) ones++;
        end
        if (par_mode != 0) begin
            e.val = ones[0] ^ (par_mode == 2);
            exp_q.push_back(e);
        end
        e.val  = 1'b1;
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    // Raise tx_start in a cycle carrying an s_tick so that every bit,
    // including the start bit, spans a whole number of tick periods.
    task automatic start_frame(input logic [7:0] d, input bit hold);
        for (int i = 0; i < 8 && s_tick !== 1'b1; i++) step();
        tx_start = 1'b1;
        din      = d;
        push_frame(d, sel);
        step();
        if (!hold) tx_start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input bit disturb, input int abort_at);
        exp_bit_t e;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < e.clks; c++) begin
                if (k == abort_at) begin
                    reset    = 1'b1;
                    tx_start = 1'b0;
                    step();
                    chk({tag, "_rst_tx"},   tx_m,   1'b1);
                    chk({tag, "_rst_busy"}, busy_m, 1'b0);
                    chk({tag, "_rst_done"}, done_m, 1'b0);
                    reset = 1'b0;
                    exp_q.delete();
                    return;
                end
                chk({tag, "_tx"},   tx_m,   e.val);
                chk({tag, "_busy"}, busy_m, 1'b1);
                chk({tag, "_done"}, done_m, e.last && (c == e.clks - 1));
                if (disturb) begin
                    if (k == 5 || k == 50 || k == 150) begin
                        tx_start = 1'b1;
                        din      = 8'($urandom);
                    end else begin
                        tx_start = 1'b0;
                    end
                end
                k++;
                step();
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_tx"},   tx_m,   1'b1);
        chk({tag, "_idle_busy"}, busy_m, 1'b0);
        chk({tag, "_idle_done"}, done_m, 1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        tx_start = 1'b0;
        din      = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        din      = 8'h00;
        s_tick   = 1'b1;

        // reset state of all three instances
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle("reset");
        end
        sel   = 0;
        reset = 1'b0;
        step();

        // basic frames, tick every clock
        start_frame(8'hA5, 1'b0);
        check_frame("t1_a5", 1'b0, -1);
        check_idle("t1_a5");
        start_frame(8'h00, 1'b0);
        check_frame("t1_00", 1'b0, -1);
        check_idle("t1_00");
        start_frame(8'hFF, 1'b0);
        check_frame("t1_ff", 1'b0, -1);
        check_idle("t1_ff");

        // parity, even then odd
        do_reset();
        sel = 1;
        start_frame(8'h07, 1'b0);
        check_frame("t2_even", 1'b0, -1);
        check_idle("t2_even");
        do_reset();
        sel = 2;
        start_frame(8'h07, 1'b0);
        check_frame("t2_odd", 1'b0, -1);
        check_idle("t2_odd");

        // tick every 4th clock
        do_reset();
        sel = 0;
        div = 4;
        start_frame(8'h3C, 1'b0);
        check_frame("t3_div4", 1'b0, -1);
        check_idle("t3_div4");
        div = 1;

        // tx_start pulses and din changes inside a frame
        do_reset();
        start_frame(8'h96, 1'b0);
        check_frame("t4_dist", 1'b0 | 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            check_idle("t4_after");
            step();
        end

        // tx_start held: back-to-back with a single idle clock
        do_reset();
        start_frame(8'h55, 1'b1);
        check_frame("t5_f1", 1'b0, -1);
        check_idle("t5_gap");
        push_frame(8'h55, 0);
        step();
        tx_start = 1'b0;
        check_frame("t5_f2", 1'b0, -1);
        check_idle("t5_end");
        step();
        check_idle("t5_end2");

        // reset in the middle of a frame, then a clean frame
        do_reset();
        start_frame(8'hA5, 1'b0);
        check_frame("t6_abort", 1'b0, 70);
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("t6_after");
        end
        start_frame(8'hC3, 1'b0);
        check_frame("t6_new", 1'b0, -1);
        check_idle("t6_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
